inst_fetch_unit: RTL

Parametrised instruction fetch stage with an internal program memory, an owned program counter, a prefetch FIFO and a valid/ready output handshake. It replaces the single-register fetch with a decoupled front end. Decode can stall via ready, and execute can redirect the PC (branch/jump), which flushes all prefetched and in-flight work. The program memory is loaded through a dedicated write port.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/inst_fetch_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch front end.
// Contents: default instruction/PC widths, fetch entry payload, perf counter width.
package fetch_pkg;

  localparam int unsigned DEF_INST_W = 19;
  localparam int unsigned DEF_PC_W   = 19;
  localparam int unsigned PERF_W     = 32;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries with flush.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           discard all contents (wins over push)
//   push, push_data write one entry
//   pop             consume head entry (caller guarantees non-empty)
//   head            current head entry (contents undefined when empty)
//   empty           no entries stored
//   count           number of stored entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             storage [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;

  // Pointer and occupancy tracking; flush simply rewinds everything.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; stale slots are harmless because pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_data;
  end

  assign head  = storage[rd_ptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/inst_fetch_unit.sv
// Decoupled instruction fetch stage: program memory, PC, prefetch FIFO and
// valid/ready output. Execute can redirect the PC, flushing prefetched and
// in-flight work.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   imem_we, imem_waddr, imem_wdata    program memory write port (always live)
//   redirect_valid, redirect_pc        load new PC and flush
//   out_ready                          decode accepts head entry
//   out_valid, out_inst, out_pc        head entry (inst/pc are 0 when empty)
//   fifo_count                         occupied FIFO entries
//   perf_fetched, perf_flushed         saturating perf counters (macro only)
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   INST_W     = DEF_INST_W,
  parameter int unsigned   PC_W       = DEF_PC_W,
  parameter int unsigned   MEM_DEPTH  = 256,
  parameter int unsigned   FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0]  imem_waddr,
  input  logic [INST_W-1:0]             imem_wdata,
  input  logic                          redirect_valid,
  input  logic [PC_W-1:0]               redirect_pc,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [INST_W-1:0]             out_inst,
  output logic [PC_W-1:0]               out_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]             perf_fetched,
  output logic [PERF_W-1:0]             perf_flushed
`endif
);

  localparam int unsigned AW    = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [INST_W-1:0] mem [MEM_DEPTH];
  logic [INST_W-1:0] rdata;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_issued;
  logic              inflight;
  logic              issue_c;
  logic              push_c;
  logic              pop_c;
  logic              fifo_empty;
  logic [CNT_W-1:0]  count;
  entry_t            head;
  entry_t            push_entry;

  // Issue only while the FIFO can absorb every outstanding read.
  assign issue_c = !reset && !redirect_valid &&
                   ((count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH));

  // A read returning in a redirect cycle is killed.
  assign push_c     = inflight && !redirect_valid;
  assign push_entry = '{pc: pc_issued, inst: rdata};
  assign pop_c      = out_valid && out_ready;

  // Program memory: synchronous read-first, write port independent of fetch.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
    if (issue_c) rdata <= mem[pc[AW-1:0]];
  end

  // PC and in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      pc_issued <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue_c;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (issue_c) begin
        pc        <= pc + PC_W'(1);
        pc_issued <= pc;
      end
    end
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push_c),
    .push_data (push_entry),
    .pop       (pop_c),
    .head      (head),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign out_valid  = !fifo_empty && !redirect_valid;
  assign out_inst   = fifo_empty ? '0 : head.inst;
  assign out_pc     = fifo_empty ? '0 : head.pc;
  assign fifo_count = count;

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W:0] flushed_sum;

  // Discarded work on redirect = buffered entries plus the killed read.
  assign flushed_sum = {1'b0, perf_flushed} + (PERF_W+1)'(count) +
                       (PERF_W+1)'(inflight);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop_c && (perf_fetched != '1)) perf_fetched <= perf_fetched + PERF_W'(1);
      if (redirect_valid) perf_flushed <= flushed_sum[PERF_W] ? '1 : flushed_sum[PERF_W-1:0];
    end
  end
`endif

endmodule
